implication_responder: RTL and testbench

Bounded-latency request/acknowledge responder: the block that produces the consequent for a request antecedent. Each accepted request is answered by exactly one acknowledge carrying the same tag, in request order. The acknowledge arrives no earlier than LATENCY cycles after acceptance, and exactly LATENCY cycles after when the acknowledge channel is not backpressured. It serves as the reference responder that the implication checks (`req |-> ##LATENCY ack`, `|=>` for LATENCY=1) are proven and covered against.

---
 rtl/implication_responder_if.sv | 40 ++++
 rtl/implication_responder.sv | 173 +++++++++++++++++
 tb/tb_implication_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/implication_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : implication_responder_if
// Description : Request/acknowledge bundle for implication_responder.
//               The master modport is the requester/consumer side. The slave
//               modport is the responder side.
//   req_valid   master->slave  request present
//   req_tag     master->slave  request tag [TAG_W]
//   req_ready   slave->master  responder can accept
//   ack_valid   slave->master  acknowledge present
//   ack_tag     slave->master  tag of the acknowledged request [TAG_W]
//   ack_ready   master->slave  consumer takes the acknowledge
//   outstanding slave->master  accepted, unacknowledged count
// Revision    : 1.0 - initial release
// ============================================================================
interface implication_responder_if #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
);
  localparam int C_CNT_W = $clog2(DEPTH + 1);

  logic               req_valid;
  logic [TAG_W-1:0]   req_tag;
  logic               req_ready;
  logic               ack_valid;
  logic [TAG_W-1:0]   ack_tag;
  logic               ack_ready;
  logic [C_CNT_W-1:0] outstanding;

  modport master (
    output req_valid, req_tag, ack_ready,
    input  req_ready, ack_valid, ack_tag, outstanding
  );

  modport slave (
    input  req_valid, req_tag, ack_ready,
    output req_ready, ack_valid, ack_tag, outstanding
  );
endinterface
`default_nettype wire

// File: rtl/implication_responder.sv
`default_nettype none
// ============================================================================
// Module      : implication_responder
// Description : Bounded-latency request/acknowledge responder. Every accepted
//               request gets exactly one acknowledge with the same tag, in
//               request order. The acknowledge comes LATENCY cycles after
//               acceptance, or later if the acknowledge channel is stalled.
//               Accepted requests first pass through a delay line of
//               LATENCY-1 stages that never stalls. They then wait in a
//               DEPTH-entry output FIFO until the consumer takes them.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               rsp    - implication_responder_if.slave (req/ack channels and
//                        the outstanding count)
// Parameters  : LATENCY (1..8), DEPTH (1..16), TAG_W
// Options     : define IMPLICATION_RESPONDER_SVA_EN to compile in the
//               protocol assertions and covers
// Revision    : 1.0 - initial release
// ============================================================================
module implication_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  implication_responder_if.slave rsp
);

  localparam int                 C_CNT_W     = $clog2(DEPTH + 1);
  localparam int                 C_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_ONE_CNT   = C_CNT_W'(1);
  localparam logic [C_PTR_W-1:0] C_LAST_PTR  = C_PTR_W'(DEPTH - 1);
  localparam logic [C_PTR_W-1:0] C_ONE_PTR   = C_PTR_W'(1);

  logic [C_CNT_W-1:0] r_count;
  logic [C_CNT_W-1:0] r_fifo_cnt;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [TAG_W-1:0]   r_mem [DEPTH];

  logic               w_req_ready;
  logic               w_accept;
  logic               w_ack_valid;
  logic               w_ack_hs;
  logic               w_fifo_wr;
  logic [TAG_W-1:0]   w_fifo_wr_tag;

  // The ready signal depends only on the registered count. It never
  // depends on req_valid, so the request side sees no combinational loop.
  assign w_req_ready = (r_count < C_DEPTH_CNT);
  assign w_accept    = rsp.req_valid && w_req_ready;
  assign w_ack_valid = (r_fifo_cnt != '0);
  assign w_ack_hs    = w_ack_valid && rsp.ack_ready;

  assign rsp.req_ready   = w_req_ready;
  assign rsp.ack_valid   = w_ack_valid;
  // Forced to zero when the FIFO is empty. The memory is not reset, so
  // this keeps ack_tag at 0 after reset.
  assign rsp.ack_tag     = w_ack_valid ? r_mem[r_rd_ptr] : '0;
  assign rsp.outstanding = r_count;

  // --------------------------------------------------------------------------
  // Delay line. It shifts every cycle, so a tag reaches the FIFO write port
  // exactly LATENCY-1 cycles after it was accepted. The FIFO write then adds
  // the last cycle of latency.
  // --------------------------------------------------------------------------
  generate
    if (LATENCY > 1) begin : g_line
      logic [LATENCY-2:0] r_vld;
      logic [TAG_W-1:0]   r_tag [LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          for (int i = 0; i < LATENCY - 1; i++) begin
            r_tag[i] <= '0;
          end
        end else begin
          r_vld[0] <= w_accept;
          r_tag[0] <= rsp.req_tag;
          for (int i = 1; i < LATENCY - 1; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
          end
        end
      end

      assign w_fifo_wr     = r_vld[LATENCY-2];
      assign w_fifo_wr_tag = r_tag[LATENCY-2];
    end else begin : g_direct
      assign w_fifo_wr     = w_accept;
      assign w_fifo_wr_tag = rsp.req_tag;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output FIFO. The number of entries in the delay line plus the FIFO
  // never exceeds the outstanding count, and that count is at most DEPTH.
  // So a write never finds the FIFO full and needs no guard.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr] <= w_fifo_wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + C_ONE_PTR;
      end
      if (w_ack_hs) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + C_ONE_PTR;
      end
      case ({w_fifo_wr, w_ack_hs})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + C_ONE_CNT;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - C_ONE_CNT;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding counter: accepted requests that have not been acknowledged.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_ack_hs})
        2'b10:   r_count <= r_count + C_ONE_CNT;
        2'b01:   r_count <= r_count - C_ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IMPLICATION_RESPONDER_SVA_EN
  default clocking cb_sva @(posedge clk); endclocking
  default disable iff (!rst_n);

  a_count_bound: assert property (r_count <= C_DEPTH_CNT);
  a_ack_has_owner: assert property (w_ack_valid |-> (r_count != '0));
  a_ack_stable: assert property (
    (w_ack_valid && !rsp.ack_ready) |=> (w_ack_valid && $stable(rsp.ack_tag))
  );

  // With nothing in flight, the answer to an accept cannot be held back
  // by older entries, so it must appear after exactly LATENCY cycles.
  generate
    if (LATENCY == 1) begin : g_sva_lat1
      a_latency: assert property (
        (r_count == '0 && !w_ack_valid && w_accept) |=> w_ack_valid
      );
    end else begin : g_sva_latn
      a_latency: assert property (
        (r_count == '0 && !w_ack_valid && w_accept) |-> ##LATENCY w_ack_valid
      );
    end
  endgenerate

  cv_latency: cover property (w_accept ##LATENCY w_ack_hs);
  cv_full:    cover property (r_count == C_DEPTH_CNT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_implication_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_implication_responder
// Description : Self-checking bench for implication_responder. The reference
//               keeps a queue of accepted requests, each stamped with its
//               accept cycle. The head of the queue may be acknowledged once
//               LATENCY cycles have passed since its accept. Outstanding is
//               the queue size. Stimulus runs as directed steps followed by
//               random phases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_implication_responder;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;

  typedef struct {
    logic [TAG_W-1:0] tag;
    int               t;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  implication_responder_if #(.TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  implication_responder #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rsp   (bus)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   now    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed=%0h expected=%0h", name, $time, obs, exp);
    end
  endtask

  // Expected outputs from the reference queue.
  task automatic model(output logic e_rdy, output logic e_av,
                       output logic [TAG_W-1:0] e_tag, output int e_out);
    e_out = q.size();
    e_rdy = (e_out < DEPTH);
    e_av  = 1'b0;
    e_tag = '0;
    if (q.size() != 0) begin
      if (now >= q[0].t + LATENCY) begin
        e_av  = 1'b1;
        e_tag = q[0].tag;
      end
    end
  endtask

  task automatic check_all();
    logic             e_rdy, e_av;
    logic [TAG_W-1:0] e_tag;
    int               e_out;
    model(e_rdy, e_av, e_tag, e_out);
    check("req_ready",   32'(bus.req_ready),   32'(e_rdy));
    check("ack_valid",   32'(bus.ack_valid),   32'(e_av));
    check("ack_tag",     32'(bus.ack_tag),     32'(e_tag));
    check("outstanding", 32'(bus.outstanding), 32'(e_out));
  endtask

  // One clock cycle. Inputs are applied just after a rising edge, and
  // outputs are checked on the falling edge. The model then advances with
  // the handshakes it predicts for this cycle.
  task automatic cyc(input logic v, input logic [TAG_W-1:0] tg, input logic ar);
    logic             e_rdy, e_av;
    logic [TAG_W-1:0] e_tag;
    int               e_out;
    ent_t             e;
    bus.req_valid = v;
    bus.req_tag   = tg;
    bus.ack_ready = ar;
    @(negedge clk);
    check_all();
    model(e_rdy, e_av, e_tag, e_out);
    @(posedge clk);
    if (e_av && ar) void'(q.pop_front());
    if (v && e_rdy) begin
      e.tag = tg;
      e.t   = now;
      q.push_back(e);
    end
    now++;
    #1;
  endtask

  // Asynchronous reset applied between edges. The effect is checked
  // before any clock edge arrives.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("rst_outstanding", 32'(bus.outstanding), 32'd0);
    check("rst_ack_valid",   32'(bus.ack_valid),   32'd0);
    check("rst_ack_tag",     32'(bus.ack_tag),     32'd0);
    check("rst_req_ready",   32'(bus.req_ready),   32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_tag   = '0;
    bus.ack_ready = 1'b0;

    // Power-on reset.
    pulse_reset();

    // A single tag 0x5 with no backpressure.
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1);

    // Back-to-back accepts at full rate.
    for (int i = 1; i <= 6; i++) cyc(1'b1, 4'(i), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b1);

    // Fill to DEPTH under backpressure. Five requests give four accepts.
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'(8 + i), 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b1, 4'hE, 1'b1);   // full: ack only, count drops to 3
    cyc(1'b1, 4'hF, 1'b1);   // accept and ack together, count holds
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b1);

    // Hold tag 0xA under backpressure, then release it.
    cyc(1'b1, 4'hA, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b1);

    // Reset with three requests outstanding. Afterwards, none of them may
    // be acknowledged, and a new request is answered after LATENCY cycles.
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'(3 + i), 1'b0);
    pulse_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'hC, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1);

    // Random traffic. The ack_ready bias changes between phases so the
    // block is driven both full and empty.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 250; i++) begin
        cyc(1'($urandom_range(0, 3) != 0),
            TAG_W'($urandom),
            1'($urandom_range(0, 3) < p + 1));
      end
      if (p == 1) pulse_reset();
    end
    for (int i = 0; i < 2 * DEPTH + LATENCY; i++) cyc(1'b0, 4'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
